top_result_collector: RTL and testbench

Downstream stage of `TOP`. It captures each result record that `TOP` produces (`d877`, `data_rd_T`, and the tag flag `f459_87_`) when `wrr_898` strobes, and buffers records in a small FIFO. It drains each record as three 32-bit beats on a valid/ready stream toward the bench/host side, keeping a drop counter and a running XOR checksum of emitted beats.

---
 rtl/top_result_collector.sv | 119 +++++++++++
 tb/tb_top_result_collector.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/top_result_collector.sv
// Collects result records from TOP into a small FIFO and drains each record
// as three 32-bit beats on a valid/ready stream, with drop counting and checksum.
module top_result_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrr_898,
  input  logic [63:0]      d877,
  input  logic [31:0]      data_rd_T,
  input  logic             f459_87_,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [31:0]      checksum
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    B0,
    B1,
    B2
  } state_t;

  state_t state, state_next;

  logic [96:0]      mem [DEPTH];
  logic [96:0]      head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_next;
  logic             handshake, pop, space, push, drop;

  assign head       = mem[rd_ptr];
  assign full       = (count == FULL_COUNT);
  assign empty      = (count == '0);
  assign out_valid  = (state != IDLE);
  assign handshake  = out_valid && out_ready;
  assign pop        = handshake && (state == B2);
  // A full FIFO still accepts a strobe when the head is leaving this cycle.
  assign space      = !full || pop;
  assign push       = wrr_898 && space;
  assign drop       = wrr_898 && !space;
  assign count_next = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= {f459_87_, data_rd_T, d877};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      checksum <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
      if (handshake) begin
        checksum <= checksum ^ out_data;
      end
    end
  end

  // Beat selection comes straight from the head entry, so it stays stable under backpressure.
  always_comb begin
    state_next = state;
    out_data   = '0;
    out_last   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_next = B0;
        end
      end
      B0: begin
        out_data = head[31:0];
        if (handshake) begin
          state_next = B1;
        end
      end
      B1: begin
        out_data = head[63:32];
        if (handshake) begin
          state_next = B2;
        end
      end
      B2: begin
        out_data = head[95:64];
        out_last = head[96];
        if (handshake) begin
          state_next = (count_next != '0) ? B0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_top_result_collector.sv
// Randomized and directed bench for top_result_collector, checked against a
// record-level queue model of the collector.
module tb_top_result_collector;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             wrr_898;
  logic [63:0]      d877;
  logic [31:0]      data_rd_T;
  logic             f459_87_;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] drop_cnt;
  logic [31:0]      checksum;

  always #5 clk = ~clk;

  top_result_collector #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wrr_898   (wrr_898),
    .d877      (d877),
    .data_rd_T (data_rd_T),
    .f459_87_  (f459_87_),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .full      (full),
    .empty     (empty),
    .drop_cnt  (drop_cnt),
    .checksum  (checksum)
  );

  typedef struct {
    logic [63:0] d;
    logic [31:0] rd;
    logic        tag;
  } rec_t;

  rec_t             mq[$];
  int               m_beat;
  bit               m_active;
  logic [CNT_W-1:0] m_drop;
  logic [31:0]      m_sum;

  int vectors;
  int miscompares;

  function automatic logic [31:0] beat_word(input rec_t r, input int b);
    case (b)
      0:       return r.d[31:0];
      1:       return r.d[63:32];
      default: return r.rd;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Record-level model: a queue of pending records plus the beat index of the head.
  task automatic modelStep(input logic rst, input logic wr, input logic [63:0] d,
                           input logic [31:0] rd, input logic tg, input logic rdy);
    bit   hs;
    bit   pops;
    bit   room;
    bit   had_records;
    rec_t r;
    if (rst) begin
      mq.delete();
      m_beat   = 0;
      m_active = 0;
      m_drop   = '0;
      m_sum    = '0;
      return;
    end
    hs          = m_active && rdy;
    pops        = hs && (m_beat == 2);
    room        = (mq.size() < DEPTH) || pops;
    had_records = (mq.size() != 0);
    if (hs) begin
      m_sum = m_sum ^ beat_word(mq[0], m_beat);
      if (pops) begin
        void'(mq.pop_front());
        m_beat = 0;
      end else begin
        m_beat++;
      end
    end
    if (wr) begin
      if (room) begin
        r.d   = d;
        r.rd  = rd;
        r.tag = tg;
        mq.push_back(r);
      end else if (m_drop != {CNT_W{1'b1}}) begin
        m_drop++;
      end
    end
    if (!m_active) begin
      m_active = had_records;
    end else if (pops) begin
      m_active = (mq.size() != 0);
    end
  endtask

  task automatic checkAll();
    logic [31:0] exp_data;
    logic        exp_last;
    exp_data = '0;
    exp_last = 1'b0;
    if (m_active) begin
      exp_data = beat_word(mq[0], m_beat);
      exp_last = (m_beat == 2) && mq[0].tag;
    end
    checkOutput("out_valid", 64'(out_valid), 64'(m_active));
    checkOutput("out_data", 64'(out_data), 64'(exp_data));
    checkOutput("out_last", 64'(out_last), 64'(exp_last));
    checkOutput("full", 64'(full), 64'(mq.size() == DEPTH));
    checkOutput("empty", 64'(empty), 64'(mq.size() == 0));
    checkOutput("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    checkOutput("checksum", 64'(checksum), 64'(m_sum));
  endtask

  task automatic applyStimulus(input logic rst, input logic wr, input logic [63:0] d,
                               input logic [31:0] rd, input logic tg, input logic rdy);
    reset     = rst;
    wrr_898   = wr;
    d877      = d;
    data_rd_T = rd;
    f459_87_  = tg;
    out_ready = rdy;
    @(posedge clk);
    modelStep(rst, wr, d, rd, tg, rdy);
    #1;
    checkAll();
  endtask

  task automatic idleCycles(input logic rdy, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, rdy);
    end
  endtask

  task automatic randomRecord(input logic rdy);
    applyStimulus(1'b0, 1'b1, {$urandom, $urandom}, $urandom, 1'($urandom_range(0, 1)), rdy);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_beat      = 0;
    m_active    = 0;
    m_drop      = '0;
    m_sum       = '0;

    doReset();
    doReset();

    // Single record, consumer always ready.
    applyStimulus(1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 32'hDEAD_BEEF, 1'b1, 1'b1);
    idleCycles(1'b1, 4);
    checkOutput("single_checksum", 64'(checksum), 64'h5625_3667);
    checkOutput("single_empty", 64'(empty), 64'h1);

    // Same record under backpressure.
    doReset();
    applyStimulus(1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 32'hDEAD_BEEF, 1'b1, 1'b0);
    idleCycles(1'b0, 5);
    checkOutput("bp_hold_data", 64'(out_data), 64'h89AB_CDEF);
    checkOutput("bp_hold_checksum", 64'(checksum), 64'h0);
    idleCycles(1'b1, 4);
    checkOutput("bp_checksum", 64'(checksum), 64'h5625_3667);

    // Overflow: six strobes into a stalled four-entry FIFO.
    doReset();
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b0, 1'b1, 64'(i), 32'(i * 16), 1'(i % 2), 1'b0);
      if (i == 4) checkOutput("ovf_full", 64'(full), 64'h1);
    end
    checkOutput("ovf_drop_cnt", 64'(drop_cnt), 64'h2);
    idleCycles(1'b1, 14);

    // Full FIFO with strobes every cycle while draining: B2 pops coincide with pushes.
    idleCycles(1'b0, 1);
    for (int i = 0; i < 4; i++) randomRecord(1'b0);
    for (int i = 0; i < 9; i++) randomRecord(1'b1);
    idleCycles(1'b1, 15);

    // Wrap-around with continuous drain.
    doReset();
    for (int i = 0; i < 10; i++) begin
      randomRecord(1'b1);
      idleCycles(1'b1, 2);
    end
    idleCycles(1'b1, 3);
    checkOutput("wrap_drop_cnt", 64'(drop_cnt), 64'h0);

    // Reset while in B1 with two records buffered; the reset-cycle strobe is ignored.
    doReset();
    randomRecord(1'b0);
    randomRecord(1'b0);
    idleCycles(1'b1, 1);
    applyStimulus(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'h0);
    checkOutput("rst_empty", 64'(empty), 64'h1);
    checkOutput("rst_checksum", 64'(checksum), 64'h0);
    checkOutput("rst_drop_cnt", 64'(drop_cnt), 64'h0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 99) == 0),
                    1'($urandom_range(0, 2) != 0),
                    {$urandom, $urandom}, $urandom,
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0));
    end
    idleCycles(1'b1, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
